// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the D-cache store path and data memory.
// Drains stores in order with a one-cycle gap between mem_wen pulses; forwards pending data to reads.
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 30,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [AW-1:0]          in_addr,
  input  logic [DW-1:0]          in_data,
  output logic                   in_ready,
  output logic                   mem_wen,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ready,
  input  logic [AW-1:0]          rd_addr,
  output logic                   rd_hit,
  output logic [DW-1:0]          rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  // state | meaning
  // IDLE  | nothing being written, waiting for a pending entry
  // WRITE | mem_wen high, head entry presented until mem_ready
  // GAP   | mem_wen low for one cycle so every store is a distinct pulse
  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] idx;
  logic [AW-1:0] buf_addr [DEPTH];
  logic [DW-1:0] buf_data [DEPTH];
  logic          push;
  logic          pop;

  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid & in_ready;
  assign pop      = mem_wen & mem_ready;
  assign empty    = (count == '0) && (state == IDLE);

  // Entry storage needs no reset: validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= in_addr;
      buf_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= WRITE;
            mem_wen   <= 1'b1;
            mem_addr  <= buf_addr[rd_ptr];
            mem_wdata <= buf_data[rd_ptr];
          end
        end
        WRITE: begin
          if (mem_ready) begin
            state   <= GAP;
            mem_wen <= 1'b0;
          end
        end
        GAP: begin
          // rd_ptr and count already reflect the pop of the previous cycle
          if (count != '0) begin
            state     <= WRITE;
            mem_wen   <= 1'b1;
            mem_addr  <= buf_addr[rd_ptr];
            mem_wdata <= buf_data[rd_ptr];
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_wen <= 1'b0;
        end
      endcase
    end
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (buf_addr[idx] == rd_addr)) begin
        rd_hit  = 1'b1;
        rd_data = buf_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer: expected memory writes go into a scoreboard queue,
// a negedge monitor pops and compares on every mem_wen&mem_ready handshake.
module tb_dmem_write_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [29:0] in_addr;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_wen;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [29:0] rd_addr;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        empty;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  int rises = 0;

  logic [29:0] exp_a [$];
  logic [31:0] exp_d [$];
  logic [29:0] ea;
  logic [31:0] ed;
  logic        prev_hs;
  logic        prev_wen;

  dmem_write_buffer #(.DEPTH(4), .AW(30), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
    .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: scoreboard compare on handshake, gap-after-pop check, rising edge count
  always @(negedge clk) begin
    if (!rst) begin
      prev_hs  = 1'b0;
      prev_wen = 1'b0;
    end else begin
      if (prev_hs) begin
        total++;
        if (mem_wen) begin
          bad++;
          $display("FAIL gap: mem_wen=%0b in cycle after pop, required 0", mem_wen);
        end
      end
      if (mem_wen && !prev_wen) rises++;
      if (mem_wen && mem_ready) begin
        total++;
        if (exp_a.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: addr=%0h data=%0h with empty scoreboard", mem_addr, mem_wdata);
        end else begin
          ea = exp_a.pop_front();
          ed = exp_d.pop_front();
          if (mem_addr !== ea || mem_wdata !== ed) begin
            bad++;
            $display("FAIL mem_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     mem_addr, mem_wdata, ea, ed);
          end
        end
      end
      prev_hs  = mem_wen && mem_ready;
      prev_wen = mem_wen;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic store(input logic [29:0] a, input logic [31:0] d);
    int n;
    in_addr  = a;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL store_wait: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end else begin
      exp_a.push_back(a);
      exp_d.push_back(d);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (!empty && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (!empty) begin
      bad++;
      $display("FAIL drain_timeout: empty=%0b count=%0d, required empty=1", empty, count);
    end
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    mem_ready = 1'b0;
    rd_addr   = '0;
    #1;
    chk("rst_mem_wen",   mem_wen,   1'b0);
    chk("rst_mem_addr",  mem_addr,  30'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_count",     count,     3'd0);
    chk("rst_empty",     empty,     1'b1);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_rd_hit",    rd_hit,    1'b0);
    #1 rst = 1'b1;

    // Single store, memory stalls three cycles of the strobe
    store(30'h10, 32'h68010000);
    chk("t1_count_acc", count, 3'd1);
    chk("t1_wen_acc", mem_wen, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_wen_hold", mem_wen, 1'b1);
      chk("t1_addr_hold", mem_addr, 30'h10);
      chk("t1_data_hold", mem_wdata, 32'h68010000);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("t1_wen_gap", mem_wen, 1'b0);
    chk("t1_count_pop", count, 3'd0);
    chk("t1_empty_gap", empty, 1'b0);
    tick();
    chk("t1_empty_idle", empty, 1'b1);
    chk("t1_wen_idle", mem_wen, 1'b0);

    // Fill to full, hold fifth store, release one slot
    store(30'h40, 32'hA0A0A0A0);
    store(30'h41, 32'hA1A1A1A1);
    store(30'h42, 32'hA2A2A2A2);
    store(30'h43, 32'hA3A3A3A3);
    chk("t2_count_full", count, 3'd4);
    chk("t2_ready_full", in_ready, 1'b0);
    in_addr  = 30'h44;
    in_data  = 32'hA4A4A4A4;
    in_valid = 1'b1;
    tick();
    chk("t2_count_held", count, 3'd4);
    chk("t2_ready_held", in_ready, 1'b0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("t2_count_pop", count, 3'd3);
    chk("t2_ready_back", in_ready, 1'b1);
    exp_a.push_back(30'h44);
    exp_d.push_back(32'hA4A4A4A4);
    tick();
    in_valid = 1'b0;
    chk("t2_count_refill", count, 3'd4);
    mem_ready = 1'b1;
    wait_empty();

    // Ordered drain with memory always ready
    rises = 0;
    store(30'h10, 32'hADDE0000);
    store(30'h10, 32'h25F60000);
    store(30'h10, 32'h00806F56);
    store(30'h10, 32'h0040AB37);
    wait_empty();
    chk("t3_rises", rises, 64'd4);
    mem_ready = 1'b0;

    // Forwarding of youngest pending store
    store(30'h20, 32'h11111111);
    store(30'h20, 32'h22222222);
    rd_addr = 30'h20;
    #1;
    chk("t4_hit", rd_hit, 1'b1);
    chk("t4_data_young", rd_data, 32'h22222222);
    rd_addr = 30'h21;
    #1;
    chk("t4_miss", rd_hit, 1'b0);
    in_addr  = 30'h30;
    in_data  = 32'h33333333;
    in_valid = 1'b1;
    rd_addr  = 30'h30;
    #1;
    chk("t4_push_invisible", rd_hit, 1'b0);
    exp_a.push_back(30'h30);
    exp_d.push_back(32'h33333333);
    tick();
    in_valid = 1'b0;
    chk("t4_push_visible", rd_hit, 1'b1);
    chk("t4_push_data", rd_data, 32'h33333333);
    mem_ready = 1'b1;
    wait_empty();
    mem_ready = 1'b0;
    rd_addr = 30'h20;
    #1;
    chk("t4_hit_after_drain", rd_hit, 1'b0);

    // Push and pop in the same cycle at count=1
    store(30'h50, 32'h50505050);
    tick();
    chk("t5_wen", mem_wen, 1'b1);
    in_addr   = 30'h51;
    in_data   = 32'h51515151;
    in_valid  = 1'b1;
    mem_ready = 1'b1;
    exp_a.push_back(30'h51);
    exp_d.push_back(32'h51515151);
    tick();
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    chk("t5_count_same", count, 3'd1);
    chk("t5_wen_gap", mem_wen, 1'b0);
    tick();
    chk("t5_wen_next", mem_wen, 1'b1);
    chk("t5_addr_next", mem_addr, 30'h51);
    mem_ready = 1'b1;
    wait_empty();
    mem_ready = 1'b0;

    // Reset in the middle of a drain
    store(30'h60, 32'h60606060);
    store(30'h61, 32'h61616161);
    store(30'h62, 32'h62626262);
    chk("t6_wen_pre", mem_wen, 1'b1);
    chk("t6_count_pre", count, 3'd3);
    #3;
    rst = 1'b0;
    exp_a.delete();
    exp_d.delete();
    #1;
    chk("t6_wen_rst", mem_wen, 1'b0);
    chk("t6_count_rst", count, 3'd0);
    chk("t6_empty_rst", empty, 1'b1);
    chk("t6_ready_rst", in_ready, 1'b1);
    #2;
    rst = 1'b1;
    rises = 0;
    mem_ready = 1'b1;
    repeat (6) tick();
    chk("t6_no_pulse", rises, 64'd0);
    chk("t6_wen_quiet", mem_wen, 1'b0);
    store(30'h70, 32'h70707070);
    wait_empty();
    chk("t6_new_pulse", rises, 64'd1);

    tick();
    chk("sb_leftover", exp_a.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
